// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: requester owner tags,
// starvation FSM states and legal parameter ranges.
package data_mem_arb_pkg;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_LCD  = 1'b1
  } owner_e;

  typedef enum logic {
    NORMAL = 1'b0,
    BOOST  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;
  localparam int STARVE_LIMIT_MIN = 1;
  localparam int STARVE_LIMIT_MAX = 255;

  // Out-of-range parameters are pulled back into the legal window rather than
  // producing a broken pipeline depth or an unreachable starvation threshold.
  function automatic int clamp_param(input int value, input int lo, input int hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the core, LCD and data-memory signals around the arbiter.
// The arbiter uses the slave modport; the surrounding datapath uses master.
interface data_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  core_req;
  logic                  core_we;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic                  core_gnt;
  logic                  core_stall;
  logic                  core_rvalid;
  logic [DATA_WIDTH-1:0] core_rdata;

  logic                  lcd_req;
  logic [ADDR_WIDTH-1:0] lcd_addr;
  logic                  lcd_gnt;
  logic                  lcd_rvalid;
  logic [DATA_WIDTH-1:0] lcd_rdata;
  logic                  lcd_boost;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rd_en;
  logic                  mem_wr_en;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output lcd_req, lcd_addr,
    output mem_rdata,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    input  lcd_gnt, lcd_rvalid, lcd_rdata, lcd_boost,
    input  mem_addr, mem_wdata, mem_rd_en, mem_wr_en
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  lcd_req, lcd_addr,
    input  mem_rdata,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    output lcd_gnt, lcd_rvalid, lcd_rdata, lcd_boost,
    output mem_addr, mem_wdata, mem_rd_en, mem_wr_en
  );

endinterface

// File: rtl/data_mem_arbiter_rd_tag_pipe.sv
// Delay line carrying {valid, owner} for each issued read so the returning
// memory data can be steered to the requester that asked for it.
module rd_tag_pipe
  import data_mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t in_tag,
  output rd_tag_t out_tag
);

  rd_tag_t [DEPTH-1:0] stage;

  // Async clear drops every read still in flight so nothing returns after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '{valid: 1'b0, owner: OWNER_CORE};
      end
    end else begin
      stage[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_tag = stage[DEPTH-1];

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single data-memory port between the core memory stage and the LCD
// reader: per-cycle arbitration, registered issue and owner-tagged read return.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               rst_n,
  data_mem_arbiter_if.slave bus
);

  localparam int RD_DEPTH =
    clamp_param(READ_LATENCY, READ_LATENCY_MIN, READ_LATENCY_MAX);
  localparam logic [7:0] STARVE_MAX =
    8'(clamp_param(STARVE_LIMIT, STARVE_LIMIT_MIN, STARVE_LIMIT_MAX));

  arb_state_e state, state_next;
  logic [7:0] wait_cnt, wait_cnt_next;

  logic core_gnt;
  logic lcd_gnt;
  logic lcd_boost;

  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  mem_rd_en_q;
  logic                  mem_wr_en_q;
  owner_e                issue_owner;

  rd_tag_t issue_tag;
  rd_tag_t ret_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NORMAL;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Boost is entered the cycle after the wait counter hits its limit, and is
  // left as soon as the LCD is served or gives up, so one boost = one access.
  always_comb begin
    wait_cnt_next = wait_cnt;
    state_next    = state;
    if (!bus.lcd_req || lcd_gnt) begin
      wait_cnt_next = '0;
    end else if (wait_cnt < STARVE_MAX) begin
      wait_cnt_next = wait_cnt + 8'd1;
    end
    unique case (state)
      NORMAL: if (wait_cnt_next == STARVE_MAX) state_next = BOOST;
      BOOST:  if (lcd_gnt || !bus.lcd_req)     state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  // Grants are gated by rst_n so neither requester sees a grant while in reset.
  always_comb begin
    lcd_boost = (state == BOOST);
    core_gnt  = rst_n & bus.core_req & ~(lcd_boost & bus.lcd_req);
    lcd_gnt   = rst_n & bus.lcd_req & ~core_gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      issue_owner <= OWNER_CORE;
    end else begin
      mem_rd_en_q <= (core_gnt & ~bus.core_we) | lcd_gnt;
      mem_wr_en_q <= core_gnt & bus.core_we;
      if (core_gnt) begin
        mem_addr_q  <= bus.core_addr;
        mem_wdata_q <= bus.core_wdata;
        issue_owner <= OWNER_CORE;
      end else if (lcd_gnt) begin
        mem_addr_q  <= bus.lcd_addr;
        issue_owner <= OWNER_LCD;
      end
    end
  end

  // The tag enters alongside the registered read enable, so it emerges exactly
  // when the memory presents the data for that read.
  assign issue_tag = '{valid: mem_rd_en_q, owner: issue_owner};

  rd_tag_pipe #(
    .DEPTH (RD_DEPTH)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_tag  (issue_tag),
    .out_tag (ret_tag)
  );

  assign bus.core_gnt    = core_gnt;
  assign bus.lcd_gnt     = lcd_gnt;
  assign bus.core_stall  = rst_n & bus.core_req & ~core_gnt;
  assign bus.lcd_boost   = lcd_boost;

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_rd_en   = mem_rd_en_q;
  assign bus.mem_wr_en   = mem_wr_en_q;

  assign bus.core_rvalid = ret_tag.valid & (ret_tag.owner == OWNER_CORE);
  assign bus.lcd_rvalid  = ret_tag.valid & (ret_tag.owner == OWNER_LCD);
  assign bus.core_rdata  = bus.mem_rdata;
  assign bus.lcd_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised and directed check of data_mem_arbiter against a cycle-level
// reference model built from grant/priority rules and an in-order return queue.
module tb_data_mem_arbiter;

  localparam int RL = 3;
  localparam int SL = 8;

  typedef struct {
    int          due;
    bit          lcd;
    logic [31:0] data;
  } ret_t;

  logic clk = 1'b0;
  logic rst_n;

  data_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  data_mem_arbiter #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .READ_LATENCY (RL),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_arr   [256];
  logic [31:0] model_mem [256];
  logic [31:0] rpipe     [RL];

  // Behavioural data memory with RL cycles from sampled read enable to data.
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem_arr[bus.mem_addr[7:0]] = bus.mem_wdata;
    rpipe[0] <= bus.mem_rd_en ? mem_arr[bus.mem_addr[7:0]] : 32'h0;
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.mem_rdata = rpipe[RL-1];

  int n_checks = 0;
  int n_fail   = 0;

  int          cyc;
  bit          m_boost;
  int          waited;
  bit          exp_rd, exp_wr;
  logic [31:0] exp_addr, exp_wdata;
  ret_t        ret_q[$];
  bit          last_cgnt, last_lgnt;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input bit rst_v, input bit c_req, input bit c_we,
                               input logic [31:0] c_addr, input logic [31:0] c_wdata,
                               input bit l_req, input logic [31:0] l_addr);
    bit          m_cgnt, m_lgnt, hit;
    logic [31:0] ra;
    ret_t        r;
    @(negedge clk);
    rst_n          = rst_v;
    bus.core_req   = c_req;
    bus.core_we    = c_we;
    bus.core_addr  = c_addr;
    bus.core_wdata = c_wdata;
    bus.lcd_req    = l_req;
    bus.lcd_addr   = l_addr;
    #1;
    cyc++;
    if (!rst_v) begin
      m_boost   = 1'b0;
      waited    = 0;
      exp_rd    = 1'b0;
      exp_wr    = 1'b0;
      exp_addr  = '0;
      exp_wdata = '0;
      ret_q.delete();
    end
    m_cgnt    = rst_v && c_req && !(m_boost && l_req);
    m_lgnt    = rst_v && l_req && !m_cgnt;
    last_cgnt = m_cgnt;
    last_lgnt = m_lgnt;

    checkOutput("core_gnt",   32'(bus.core_gnt),   32'(m_cgnt));
    checkOutput("lcd_gnt",    32'(bus.lcd_gnt),    32'(m_lgnt));
    checkOutput("core_stall", 32'(bus.core_stall), 32'(rst_v && c_req && !m_cgnt));
    checkOutput("lcd_boost",  32'(bus.lcd_boost),  32'(m_boost));
    checkOutput("mem_rd_en",  32'(bus.mem_rd_en),  32'(exp_rd));
    checkOutput("mem_wr_en",  32'(bus.mem_wr_en),  32'(exp_wr));
    checkOutput("mem_addr",   bus.mem_addr,        exp_addr);
    if (exp_wr) checkOutput("mem_wdata", bus.mem_wdata, exp_wdata);

    hit = (ret_q.size() > 0) && (ret_q[0].due == cyc);
    r   = hit ? ret_q[0] : '{due: 0, lcd: 1'b0, data: 32'h0};
    checkOutput("core_rvalid", 32'(bus.core_rvalid), 32'(hit && !r.lcd));
    checkOutput("lcd_rvalid",  32'(bus.lcd_rvalid),  32'(hit && r.lcd));
    if (hit) begin
      if (r.lcd) checkOutput("lcd_rdata",  bus.lcd_rdata,  r.data);
      else       checkOutput("core_rdata", bus.core_rdata, r.data);
      void'(ret_q.pop_front());
    end

    if (m_cgnt || m_lgnt) exp_addr = m_cgnt ? c_addr : l_addr;
    if (m_cgnt) exp_wdata = c_wdata;
    exp_rd = m_lgnt || (m_cgnt && !c_we);
    exp_wr = m_cgnt && c_we;
    if (exp_wr) begin
      ra = c_addr;
      model_mem[ra[7:0]] = c_wdata;
    end
    if (exp_rd) begin
      ra = exp_addr;
      ret_q.push_back('{due: cyc + 1 + RL, lcd: m_lgnt, data: model_mem[ra[7:0]]});
    end
    if (rst_v) begin
      if (l_req && !m_lgnt) waited = (waited < SL) ? waited + 1 : SL;
      else                  waited = 0;
      m_boost = !m_boost && (waited == SL);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
  endtask

  int          first_boost;
  int          lcd_grants;
  int          boost_seen;
  bit          c_req, c_we, l_req;
  logic [31:0] c_addr, c_wdata, l_addr;

  initial begin
    rst_n = 1'b1;
    bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0;
    bus.lcd_req = 0; bus.lcd_addr = 0;
    cyc = 0;
    for (int i = 0; i < RL; i++) rpipe[i] = 32'h0;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i]   = $urandom;
      model_mem[i] = mem_arr[i];
    end
    mem_arr[8'h10]   = 32'hDEADBEEF;
    model_mem[8'h10] = 32'hDEADBEEF;
    #1;

    // Reset, including requests held while reset is asserted.
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 32'h10, 0, 1, 32'h11);
    idle(2);

    // Core read, core write, then LCD read of the freshly written word.
    applyStimulus(1, 1, 0, 32'h10, 0, 0, 0);
    idle(RL + 2);
    applyStimulus(1, 1, 1, 32'h20, 32'h1234, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 32'h20);
    idle(RL + 2);

    // Continuous contention: LCD must win once on the ninth cycle.
    first_boost = -1;
    for (int i = 1; i <= 14; i++) begin
      applyStimulus(1, 1, 0, 32'h30 + 32'(i), 0, 1, 32'h40);
      if (bus.lcd_boost && first_boost < 0) first_boost = i;
    end
    checkOutput("first_boost_cycle", 32'(first_boost), 32'(SL + 1));
    idle(RL + 2);

    // Interleaved core/LCD/core reads back to back.
    applyStimulus(1, 1, 0, 32'h50, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 32'h51);
    applyStimulus(1, 1, 0, 32'h52, 0, 0, 0);
    idle(RL + 3);

    // LCD-only streaming reads.
    lcd_grants = 0;
    boost_seen = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 1, 32'h60 + 32'(i));
      lcd_grants += int'(bus.lcd_gnt);
      boost_seen += int'(bus.lcd_boost);
    end
    checkOutput("lcd_stream_grants", 32'(lcd_grants), 32'd4);
    checkOutput("lcd_stream_boost",  32'(boost_seen), 32'd0);
    idle(RL + 2);

    // Reset pulse one cycle after a read grant: the read must never return.
    applyStimulus(1, 1, 0, 32'h70, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    idle(RL + 4);

    // Randomised traffic with held-until-granted requests.
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; l_req = 0; l_addr = 0;
    for (int i = 0; i < 600; i++) begin
      if (!c_req || last_cgnt || ($urandom_range(0, 99) < 3)) begin
        c_req   = ($urandom_range(0, 99) < 70);
        c_we    = ($urandom_range(0, 99) < 35);
        c_addr  = 32'($urandom_range(0, 255));
        c_wdata = $urandom;
      end
      if (!l_req || last_lgnt || ($urandom_range(0, 99) < 3)) begin
        l_req  = ($urandom_range(0, 99) < 50);
        l_addr = 32'($urandom_range(0, 255));
      end
      applyStimulus(1, c_req, c_we, c_addr, c_wdata, l_req, l_addr);
    end
    idle(RL + 3);
    checkOutput("returns_drained", 32'(ret_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
